// File: rtl/br_puf_sampler.sv
// Readout controller for a bistable-ring PUF macro.
// For each request it latches the challenge, pulses the ring reset, waits
// for the ring to settle, then takes SAMPLES synchronized readings. It
// returns the majority vote, the ones count and an instability flag, and
// keeps a saturating count of unstable responses.
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   IDLE     | ready for a challenge, REQ_READY=1
//   RING_RST | RING_RESET held high for RST_CYCLES
//   SETTLE   | ring released, waiting SETTLE_CYCLES before sampling
//   SAMPLE   | counting synchronized ones over SAMPLES cycles
//   RESP     | response presented, waiting for RSP_READY
module br_puf_sampler #(
    parameter int WIDTH         = 128,
    parameter int RST_CYCLES    = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int SAMPLES       = 7,
    parameter int STAT_W        = 16
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         REQ_VALID,
    output logic                         REQ_READY,
    input  logic [WIDTH-1:0]             REQ_CHAL,
    output logic [WIDTH-1:0]             RING_C,
    output logic                         RING_RESET,
    input  logic                         RING_OUT,
    output logic                         RSP_VALID,
    input  logic                         RSP_READY,
    output logic                         RSP_BIT,
    output logic [$clog2(SAMPLES+1)-1:0] RSP_ONES,
    output logic                         RSP_UNSTABLE,
    output logic [STAT_W-1:0]            STAT_UNSTABLE
);

    localparam int ONES_W   = $clog2(SAMPLES + 1);
    localparam int MAX_A    = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int MAX_CNT  = (MAX_A > SAMPLES) ? MAX_A : SAMPLES;
    localparam int CNT_W    = $clog2(MAX_CNT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RING_RST,
        ST_SETTLE,
        ST_SAMPLE,
        ST_RESP
    } state_t;

    state_t              state_q, state_nxt;
    logic [CNT_W-1:0]    cnt_q, cnt_nxt;
    logic                cnt_done;
    logic                accept;
    logic                ring_rst_end;
    logic                sample_en;
    logic                sample_last;

    logic                sync_q1, sync_q2;
    logic [ONES_W-1:0]   ones_q;
    logic [ONES_W-1:0]   ones_nxt;
    logic                unstable_nxt;

    assign cnt_done     = (cnt_q == '0);
    assign ones_nxt     = ones_q + ONES_W'(sync_q2);
    assign unstable_nxt = (ones_nxt != '0) && (ones_nxt != ONES_W'(SAMPLES));

    assign REQ_READY = (state_q == ST_IDLE);
    assign RSP_VALID = (state_q == ST_RESP);

    // State register and the shared phase timer.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    // Next-state logic; the timer is reloaded on every phase entry.
    always_comb begin
        state_nxt    = state_q;
        cnt_nxt      = cnt_q;
        accept       = 1'b0;
        ring_rst_end = 1'b0;
        sample_en    = 1'b0;
        sample_last  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (REQ_VALID) begin
                    accept    = 1'b1;
                    state_nxt = ST_RING_RST;
                    cnt_nxt   = CNT_W'(RST_CYCLES - 1);
                end
            end
            ST_RING_RST: begin
                if (cnt_done) begin
                    ring_rst_end = 1'b1;
                    state_nxt    = ST_SETTLE;
                    cnt_nxt      = CNT_W'(SETTLE_CYCLES - 1);
                end else begin
                    cnt_nxt = cnt_q - 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cnt_done) begin
                    state_nxt = ST_SAMPLE;
                    cnt_nxt   = CNT_W'(SAMPLES - 1);
                end else begin
                    cnt_nxt = cnt_q - 1'b1;
                end
            end
            ST_SAMPLE: begin
                sample_en = 1'b1;
                if (cnt_done) begin
                    sample_last = 1'b1;
                    state_nxt   = ST_RESP;
                end else begin
                    cnt_nxt = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (RSP_READY) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Two-flop synchronizer on the raw ring output, free-running.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= RING_OUT;
            sync_q2 <= sync_q1;
        end
    end

    // Challenge latch and ring reset pulse to the macro.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            RING_C     <= '0;
            RING_RESET <= 1'b0;
        end else if (accept) begin
            RING_C     <= REQ_CHAL;
            RING_RESET <= 1'b1;
        end else if (ring_rst_end) begin
            RING_RESET <= 1'b0;
        end
    end

    // Ones accumulation; cleared at accept so SETTLE leaves it untouched.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ones_q <= '0;
        end else if (accept) begin
            ones_q <= '0;
        end else if (sample_en) begin
            ones_q <= ones_nxt;
        end
    end

    // Result fields and unstable statistic, updated on the last sample edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            RSP_BIT       <= 1'b0;
            RSP_ONES      <= '0;
            RSP_UNSTABLE  <= 1'b0;
            STAT_UNSTABLE <= '0;
        end else if (sample_last) begin
            RSP_ONES     <= ones_nxt;
            RSP_BIT      <= (ones_nxt > ONES_W'(SAMPLES / 2));
            RSP_UNSTABLE <= unstable_nxt;
            if (unstable_nxt && (STAT_UNSTABLE != {STAT_W{1'b1}})) begin
                STAT_UNSTABLE <= STAT_UNSTABLE + STAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_br_puf_sampler.sv
// Directed bench for br_puf_sampler: a default-parameter instance and a
// small one (SAMPLES=3, STAT_W=2) to exercise statistic saturation.
module tb_br_puf_sampler;

    logic         CLK;
    logic         RESET;

    logic         REQ_VALID, REQ_READY, RING_RESET, RING_OUT;
    logic         RSP_VALID, RSP_READY, RSP_BIT, RSP_UNSTABLE;
    logic [127:0] REQ_CHAL, RING_C;
    logic [2:0]   RSP_ONES;
    logic [15:0]  STAT_UNSTABLE;

    logic         req_valid_b, req_ready_b, ring_reset_b, ring_out_b;
    logic         rsp_valid_b, rsp_ready_b, rsp_bit_b, rsp_unstable_b;
    logic [7:0]   req_chal_b, ring_c_b;
    logic [1:0]   rsp_ones_b;
    logic [1:0]   stat_b;

    int n_vec  = 0;
    int n_miss = 0;

    br_puf_sampler dut_a (
        .CLK(CLK), .RESET(RESET),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_CHAL(REQ_CHAL),
        .RING_C(RING_C), .RING_RESET(RING_RESET), .RING_OUT(RING_OUT),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_BIT(RSP_BIT),
        .RSP_ONES(RSP_ONES), .RSP_UNSTABLE(RSP_UNSTABLE), .STAT_UNSTABLE(STAT_UNSTABLE)
    );

    br_puf_sampler #(
        .WIDTH(8), .RST_CYCLES(1), .SETTLE_CYCLES(2), .SAMPLES(3), .STAT_W(2)
    ) dut_b (
        .CLK(CLK), .RESET(RESET),
        .REQ_VALID(req_valid_b), .REQ_READY(req_ready_b), .REQ_CHAL(req_chal_b),
        .RING_C(ring_c_b), .RING_RESET(ring_reset_b), .RING_OUT(ring_out_b),
        .RSP_VALID(rsp_valid_b), .RSP_READY(rsp_ready_b), .RSP_BIT(rsp_bit_b),
        .RSP_ONES(rsp_ones_b), .RSP_UNSTABLE(rsp_unstable_b), .STAT_UNSTABLE(stat_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // One evaluation on dut_a, entered and left at a falling edge.
    // Cycle c is the c-th cycle after the accept edge; samples are taken
    // in cycles 21..27 from RING_OUT driven in cycles 19..25.
    task automatic eval_a(input logic [127:0] chal, input logic [127:0] chal2,
                          input logic [6:0] pat, input int hold,
                          input bit busy_pulse, input bit overlap,
                          input int exp_ones, input int exp_bit,
                          input int exp_unst, input int exp_stat);
        REQ_VALID = 1'b1;
        REQ_CHAL  = chal;
        next_cycle();
        REQ_VALID = 1'b0;
        REQ_CHAL  = ~chal;
        for (int c = 1; c <= 28; c++) begin
            chk("ring_c", RING_C, chal);
            chk("ring_reset", RING_RESET, (c <= 4));
            chk("rsp_valid", RSP_VALID, (c == 28));
            chk("req_ready_busy", REQ_READY, 1'b0);
            if (c == 28) begin
                chk("rsp_ones", RSP_ONES, exp_ones);
                chk("rsp_bit", RSP_BIT, exp_bit);
                chk("rsp_unstable", RSP_UNSTABLE, exp_unst);
                chk("stat", STAT_UNSTABLE, exp_stat);
            end
            RING_OUT = (c >= 19 && c <= 25) ? pat[c-19] : ~pat[0];
            if (busy_pulse) REQ_VALID = (c == 10);
            if (c < 28) next_cycle();
        end
        for (int i = 0; i < hold; i++) begin
            next_cycle();
            chk("hold_valid", RSP_VALID, 1'b1);
            chk("hold_req_ready", REQ_READY, 1'b0);
            chk("hold_ones", RSP_ONES, exp_ones);
            chk("hold_bit", RSP_BIT, exp_bit);
            chk("hold_unst", RSP_UNSTABLE, exp_unst);
        end
        RSP_READY = 1'b1;
        if (overlap) begin
            REQ_VALID = 1'b1;
            REQ_CHAL  = chal2;
        end
        next_cycle();
        RSP_READY = 1'b0;
        chk("post_valid", RSP_VALID, 1'b0);
        chk("post_req_ready", REQ_READY, 1'b1);
        chk("post_ring_reset", RING_RESET, 1'b0);
        chk("post_ring_c", RING_C, chal);
        chk("post_ones", RSP_ONES, exp_ones);
        chk("post_stat", STAT_UNSTABLE, exp_stat);
    endtask

    logic [2:0] patb;
    int         stat_exp_b [5] = '{1, 2, 3, 3, 3};

    initial begin
        RESET = 1'b1;
        REQ_VALID = 1'b0; REQ_CHAL = '0; RING_OUT = 1'b1; RSP_READY = 1'b0;
        req_valid_b = 1'b0; req_chal_b = '0; ring_out_b = 1'b0; rsp_ready_b = 1'b0;
        #3;
        chk("rst_req_ready", REQ_READY, 1'b1);
        chk("rst_ring_c", RING_C, 128'h0);
        chk("rst_ring_reset", RING_RESET, 1'b0);
        chk("rst_rsp_valid", RSP_VALID, 1'b0);
        chk("rst_rsp_ones", RSP_ONES, 0);
        chk("rst_stat", STAT_UNSTABLE, 0);
        chk("rst_b_stat", stat_b, 0);
        next_cycle();
        next_cycle();
        RESET = 1'b0;
        next_cycle();
        chk("idle_req_ready", REQ_READY, 1'b1);
        chk("idle_rsp_valid", RSP_VALID, 1'b0);

        // 1: stable ones
        eval_a({16{8'hA5}}, '0, 7'b1111111, 0, 1'b0, 1'b0, 7, 1, 0, 0);
        // 2: first three samples 0, rest 1
        eval_a(128'h1234, '0, 7'b1111000, 0, 1'b0, 1'b0, 4, 1, 1, 1);
        // 3: consumer stalls, REQ_VALID pulsed while busy; single 1 sample
        eval_a(128'hBEEF, '0, 7'b0000001, 10, 1'b1, 1'b0, 1, 0, 1, 2);
        for (int i = 0; i < 5; i++) begin
            chk("no_second_eval_ready", REQ_READY, 1'b1);
            chk("no_second_eval_rr", RING_RESET, 1'b0);
            next_cycle();
        end
        // 4: back-to-back, second request held during the handshake
        eval_a(128'hC0FFEE, 128'hF00D, 7'b0000000, 0, 1'b0, 1'b1, 0, 0, 0, 2);
        eval_a(128'hF00D, '0, 7'b0111111, 0, 1'b0, 1'b0, 6, 1, 1, 3);

        // 5: reset during SETTLE of an unstable evaluation
        REQ_VALID = 1'b1;
        REQ_CHAL  = 128'h5555;
        next_cycle();
        REQ_VALID = 1'b0;
        for (int c = 1; c < 10; c++) begin
            RING_OUT = c[0];
            next_cycle();
        end
        RESET = 1'b1;
        #1;
        chk("abort_req_ready", REQ_READY, 1'b1);
        chk("abort_ring_c", RING_C, 128'h0);
        chk("abort_ring_reset", RING_RESET, 1'b0);
        chk("abort_rsp_valid", RSP_VALID, 1'b0);
        chk("abort_rsp_bit", RSP_BIT, 1'b0);
        chk("abort_rsp_ones", RSP_ONES, 0);
        chk("abort_rsp_unst", RSP_UNSTABLE, 1'b0);
        chk("abort_stat", STAT_UNSTABLE, 0);
        next_cycle();
        RESET = 1'b0;
        for (int c = 0; c < 25; c++) begin
            RING_OUT = c[0];
            next_cycle();
            chk("abort_no_valid", RSP_VALID, 1'b0);
            chk("abort_stat_hold", STAT_UNSTABLE, 0);
        end
        eval_a(128'h77, '0, 7'b1111111, 0, 1'b0, 1'b0, 7, 1, 0, 0);

        // 6: small instance, five unstable evaluations saturate the statistic
        patb = 3'b010;
        for (int e = 0; e < 5; e++) begin
            req_valid_b = 1'b1;
            req_chal_b  = 8'(e + 1);
            next_cycle();
            req_valid_b = 1'b0;
            for (int c = 1; c <= 7; c++) begin
                chk("b_ring_reset", ring_reset_b, (c == 1));
                chk("b_rsp_valid", rsp_valid_b, (c == 7));
                if (c == 7) begin
                    chk("b_ones", rsp_ones_b, 1);
                    chk("b_bit", rsp_bit_b, 1'b0);
                    chk("b_unst", rsp_unstable_b, 1'b1);
                    chk("b_stat", stat_b, stat_exp_b[e]);
                end
                ring_out_b = (c >= 2 && c <= 4) ? patb[c-2] : ~patb[0];
                if (c < 7) next_cycle();
            end
            rsp_ready_b = 1'b1;
            next_cycle();
            rsp_ready_b = 1'b0;
            chk("b_post_valid", rsp_valid_b, 1'b0);
            chk("b_post_ready", req_ready_b, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
